// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl_if
// Purpose  : Start/operand/result bundle for the bit-serial adder controller.
// Revision : 1.0
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] aop;
    logic [WIDTH-1:0] bop;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, aop, bop,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, aop, bop,
        output busy, done, sum, cout
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : Multi-bit adder that reuses one full-adder cell over WIDTH clocks.
// Revision : 1.0
// ============================================================================

module serial_adder_fa (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_cin,
    output logic      o_sum,
    output logic      o_carry
);
    logic w_p;

    assign w_p     = i_a ^ i_b;
    assign o_sum   = w_p ^ i_cin;
    assign o_carry = (i_a & i_b) | (w_p & i_cin);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    serial_adder_ctrl_if.slave   bus
);
    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_s_sr;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_fa_sum;
    logic               w_fa_carry;
    logic [WIDTH-1:0]   w_s_next;
    logic               w_load;
    logic               w_last;

    serial_adder_fa u_fa (
        .i_a     (r_a_sr[0]),
        .i_b     (r_b_sr[0]),
        .i_cin   (r_carry),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    // New bit enters at the MSB; after WIDTH shifts the LSB-first stream is in order.
    assign w_s_next = WIDTH'({w_fa_sum, r_s_sr} >> 1);
    assign w_load   = (r_state == S_IDLE) && bus.start;
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == c_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a_sr  <= bus.aop;
            r_b_sr  <= bus.bop;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sr  <= r_a_sr >> 1;
            r_b_sr  <= r_b_sr >> 1;
            r_s_sr  <= w_s_next;
            r_carry <= w_fa_carry;
            r_cnt   <= r_cnt + c_cnt_w'(1);
            // Result is published only once complete so no partial sum is ever visible.
            if (w_last) begin
                r_sum  <= w_s_next;
                r_cout <= w_fa_carry;
            end
        end
    end

    assign bus.busy = (r_state == S_SHIFT);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule
`default_nettype wire
